// File: rtl/lab6_soc_usb_rst_seq_if.sv
`default_nettype none
// lab6_soc_usb_rst_seq_if: Avalon-MM (zero wait, zero read latency) register port bundle.
interface lab6_soc_usb_rst_seq_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface
`default_nettype wire

// File: rtl/lab6_soc_usb_rst_seq.sv
`default_nettype none
// lab6_soc_usb_rst_seq: timed MAX3421E reset (min assert width + settle) with Avalon status/pulse counter.
// Optional ready interrupt enabled by defining USB_RST_SEQ_IRQ_EN.
module lab6_soc_usb_rst_seq #(
   parameter int ASSERT_CYCLES = 500,
   parameter int SETTLE_CYCLES = 50000,
   parameter int CNT_W         = 20
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   rst_req_n,
   lab6_soc_usb_rst_seq_if.slave  s1,
   output logic                   usb_rst_n,
   output logic                   usb_ready,
   output logic                   irq
);

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      SETTLE = 2'd1,
      READY  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             req_meta, req_s;
   logic [7:0]       pulse_cnt;
   logic             wr_en, pulse_clr, pulse_inc, busy;
   wire              unused_wdata = ^s1.writedata;

   // Reset value 0 means "request asserted" so the controller starts held in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_meta <= 1'b0;
         req_s    <= 1'b0;
      end else begin
         req_meta <= rst_req_n;
         req_s    <= req_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= HOLD;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         HOLD:    if (req_s && cnt >= ASSERT_LAST) state_next = SETTLE;
         SETTLE: begin
            if (!req_s)                  state_next = HOLD;
            else if (cnt == SETTLE_LAST) state_next = READY;
         end
         READY:   if (!req_s) state_next = HOLD;
         default: state_next = HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                              cnt <= '0;
      else if (state_next != state)              cnt <= '0;
      else if (state != READY && cnt != CNT_MAX) cnt <= cnt + 1'b1;
   end

   assign usb_rst_n = (state != HOLD);
   assign usb_ready = (state == READY);
   assign busy      = (state != READY);

   assign wr_en     = s1.chipselect & ~s1.write_n;
   assign pulse_clr = wr_en && (s1.address == 2'd1);
   assign pulse_inc = (state == HOLD) && (state_next == SETTLE);

   // A software clear landing on the same edge as an increment leaves the counter at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       pulse_cnt <= 8'd0;
      else if (pulse_clr) pulse_cnt <= 8'd0;
      else if (pulse_inc) pulse_cnt <= pulse_cnt + 8'd1;
   end

`ifdef USB_RST_SEQ_IRQ_EN
   logic irq_pend;
   logic irq_set, irq_ack;

   assign irq_set = (state == SETTLE) && (state_next == READY);
   assign irq_ack = wr_en && (s1.address == 2'd2) && s1.writedata[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     irq_pend <= 1'b0;
      else if (irq_set) irq_pend <= 1'b1;
      else if (irq_ack) irq_pend <= 1'b0;
   end

   assign irq = irq_pend;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      s1.readdata = '0;
      if (s1.chipselect) begin
         case (s1.address)
            2'd0:    s1.readdata[4:0] = {irq, state, busy, usb_ready};
            2'd1:    s1.readdata[7:0] = pulse_cnt;
            default: s1.readdata = '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lab6_soc_usb_rst_seq.sv
`default_nettype none
// Bench for lab6_soc_usb_rst_seq: register vector table, scoreboarded reads and timed reset sequences.
module tb_lab6_soc_usb_rst_seq;
   localparam int A_CYC = 4;
   localparam int S_CYC = 8;
`ifdef USB_RST_SEQ_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif
   localparam logic [31:0] STATUS_RDY = IRQ_EN ? 32'h19 : 32'h09;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rst_req_n = 1'b1;
   logic usb_rst_n, usb_ready, irq;

   lab6_soc_usb_rst_seq_if bus();

   lab6_soc_usb_rst_seq #(.ASSERT_CYCLES(A_CYC), .SETTLE_CYCLES(S_CYC), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .rst_req_n(rst_req_n), .s1(bus),
      .usb_rst_n(usb_rst_n), .usb_ready(usb_ready), .irq(irq));

   always #5 clk = ~clk;

   typedef struct { string name; logic [31:0] exp; } sb_t;
   typedef struct { logic [1:0] addr; logic cs; logic [31:0] exp; string name; } vec_t;

   sb_t  sb[$];
   vec_t vecs[7];
   int   total = 0;
   int   bad = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic sb_check(logic [31:0] act);
      sb_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL sb_empty: got 0x%08h want a queued expectation", act);
      end else begin
         e = sb.pop_front();
         check(e.name, act, e.exp);
      end
   endtask

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(logic [1:0] a, logic cs, logic [31:0] exp, string name);
      bus.address = a; bus.chipselect = cs; bus.write_n = 1'b1;
      sb.push_back('{name, exp});
      @(negedge clk);
      sb_check(bus.readdata);
      bus.chipselect = 1'b0;
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
      step();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic wait_level(logic lvl, string tag);
      int n = 0;
      @(negedge clk);
      while (usb_rst_n !== lvl && n < 40) begin n++; @(negedge clk); end
      if (usb_rst_n !== lvl) begin
         total++; bad++;
         $display("FAIL %s_timeout: usb_rst_n=%0b want %0b", tag, usb_rst_n, lvl);
      end
   endtask

   task automatic wait_ready(string tag);
      int n = 0;
      while (usb_ready !== 1'b1 && n < 40) begin n++; @(negedge clk); end
      if (usb_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL %s_timeout: usb_ready=%0b want 1", tag, usb_ready);
      end
   endtask

   // pre: high samples before reset asserts; lo: low cycles; hi: settle cycles before ready.
   task automatic measure(string tag, output int pre, output int lo, output int hi, output bit early);
      int n = 0;
      pre = 0; lo = 0; hi = 0; early = 1'b0;
      @(negedge clk);
      while (usb_rst_n && n < 40) begin
         if (usb_ready) early = 1'b1;
         pre++; n++; @(negedge clk);
      end
      while (!usb_rst_n && n < 80) begin lo++; n++; @(negedge clk); end
      while (usb_rst_n && !usb_ready && n < 120) begin hi++; n++; @(negedge clk); end
      if (usb_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL %s_timeout: usb_ready=%0b want 1", tag, usb_ready);
      end
   endtask

   task automatic pulse(string tag, output int pre, output int lo, output int hi, output bit early);
      rst_req_n = 1'b0;
      step();
      rst_req_n = 1'b1;
      measure(tag, pre, lo, hi, early);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1);
   end

   initial begin
      int pre, lo, hi;
      bit early;

      vecs[0] = '{2'd0, 1'b1, STATUS_RDY, "ready_status"};
      vecs[1] = '{2'd1, 1'b1, 32'd1,      "ready_pulses"};
      vecs[2] = '{2'd2, 1'b1, 32'd0,      "ack_reads_0"};
      vecs[3] = '{2'd3, 1'b1, 32'd0,      "rsvd_reads_0"};
      vecs[4] = '{2'd0, 1'b0, 32'd0,      "cs_low_status"};
      vecs[5] = '{2'd1, 1'b0, 32'd0,      "cs_low_pulses"};
      vecs[6] = '{2'd3, 1'b0, 32'd0,      "cs_low_rsvd"};

      bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;

      // Reset state
      step(3);
      check("rst_usb_rst_n", usb_rst_n, 0);
      check("rst_usb_ready", usb_ready, 0);
      check("rst_irq", irq, 0);
      rd(2'd0, 1'b0, 32'h0, "rst_cs_low");
      rd(2'd0, 1'b1, 32'h2, "rst_status");
      rd(2'd1, 1'b1, 32'h0, "rst_pulses");

      // 1: release with no request pending
      step();
      reset_n = 1'b1;
      measure("t1", pre, lo, hi, early);
      check("t1_pre", pre, 0);
      check("t1_low_cycles", lo, A_CYC);
      check("t1_settle_cycles", hi, S_CYC);
      check("t1_irq", irq, IRQ_EN);

      wr(2'd3, 32'hFFFF_FFFF);
      for (int i = 0; i < 7; i++) rd(vecs[i].addr, vecs[i].cs, vecs[i].exp, vecs[i].name);

      // 4: interrupt acknowledge
      wr(2'd2, 32'h0000_0001);
      check("t4_irq_after_ack", irq, 0);
      rd(2'd0, 1'b1, 32'h09, "t4_status_after_ack");

      // 2: one-cycle request in READY is stretched
      @(negedge clk);
      pulse("t2", pre, lo, hi, early);
      check("t2_latency", pre, 2);
      check("t2_low_cycles", lo, A_CYC);
      check("t2_settle_cycles", hi, S_CYC);
      rd(2'd1, 1'b1, 32'd2, "t2_pulses");
      wr(2'd2, 32'h0000_0001);

      // 3: request during settle cycle 5 abandons settle
      rst_req_n = 1'b0;
      step();
      rst_req_n = 1'b1;
      wait_level(1'b0, "t3_hold");
      wait_level(1'b1, "t3_settle");
      step(4);
      rst_req_n = 1'b0;
      step();
      rst_req_n = 1'b1;
      measure("t3", pre, lo, hi, early);
      check("t3_pre", pre, 2);
      check("t3_no_early_ready", early, 0);
      check("t3_low_cycles", lo, A_CYC);
      check("t3_settle_cycles", hi, S_CYC);
      rd(2'd1, 1'b1, 32'd4, "t3_pulses");

      // 5: 260 pulses wrap the 8-bit counter
      wr(2'd1, 32'h0);
      rd(2'd1, 1'b1, 32'd0, "t5_cleared");
      for (int i = 0; i < 260; i++) pulse("t5", pre, lo, hi, early);
      rd(2'd1, 1'b1, 32'd4, "t5_wrapped");

      // 5: clear coincident with HOLD->SETTLE
      step();
      rst_req_n = 1'b0;
      step();
      rst_req_n = 1'b1;
      step(5);
      check("t5_still_hold", usb_rst_n, 0);
      wr(2'd1, 32'h0);
      check("t5_now_settle", {usb_rst_n, usb_ready}, 2'b10);
      rd(2'd1, 1'b1, 32'd0, "t5_clear_wins");
      wait_ready("t5_ready");

      // 6: asynchronous reset mid-settle
      step();
      rst_req_n = 1'b0;
      step();
      rst_req_n = 1'b1;
      wait_level(1'b0, "t6_hold");
      wait_level(1'b1, "t6_settle");
      step(2);
      rd(2'd1, 1'b1, 32'd1, "t6_pulses_before");
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_usb_rst_n", usb_rst_n, 0);
      check("t6_usb_ready", usb_ready, 0);
      check("t6_irq", irq, 0);
      bus.chipselect = 1'b1; bus.address = 2'd1;
      sb.push_back('{"t6_pulses", 32'd0});
      #1; sb_check(bus.readdata);
      bus.address = 2'd3;
      sb.push_back('{"t6_rsvd", 32'd0});
      #1; sb_check(bus.readdata);
      bus.address = 2'd0;
      sb.push_back('{"t6_status", 32'h2});
      #1; sb_check(bus.readdata);
      bus.chipselect = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
